// File: rtl/evm_pkg.sv
// rtl/evm_pkg.sv - shared types and constants for the vote session controller
// Purpose : session state encoding, error code values and default widths.
// Ports   : none (package).
// Config  : VOTE_CONFIRM_EN adds the CONFIRM state to the session enum.
package evm_pkg;

  localparam int DEF_NUM_CANDIDATES = 3;
  localparam int DEF_NUM_VOTERS     = 4;
  localparam int DEF_ID_W           = 4;
  localparam int DEF_TIMEOUT_CYCLES = 1000;
  localparam int DEF_TOTAL_W        = 8;

  localparam logic [1:0] ERR_BAD_ID        = 2'd0;
  localparam logic [1:0] ERR_ALREADY_VOTED = 2'd1;
  localparam logic [1:0] ERR_MULTI_PRESS   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT       = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_AUTH    = 3'd1,
    S_SELECT  = 3'd2,
`ifdef VOTE_CONFIRM_EN
    S_CONFIRM = 3'd3,
`endif
    S_CAST    = 3'd4,
    S_LOCK    = 3'd5
  } session_state_t;

endpackage

// File: rtl/session_timer.sv
// rtl/session_timer.sv - loadable down-counter bounding the time spent choosing
// Purpose : counts session cycles down from TIMEOUT_CYCLES while enabled.
// Ports   : clk, rst (async, active-high)
//           load    - reload with TIMEOUT_CYCLES (wins over en)
//           en      - decrement this cycle
//           expired - the current enabled cycle is the one that reaches zero
module session_timer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= TIMER_W'(TIMEOUT_CYCLES);
    end else if (en && count != '0) begin
      count <= count - TIMER_W'(1);
    end
  end

  // Flag the cycle whose decrement takes the count to zero, so the owner
  // sees exactly TIMEOUT_CYCLES enabled cycles before aborting.
  assign expired = en && (count <= TIMER_W'(1));

endmodule

// File: rtl/vote_session_controller.sv
// rtl/vote_session_controller.sv - per-voter session sequencer ahead of the memory control unit
// Purpose : authenticates a voter, takes exactly one candidate press and emits
//           one cast strobe per session; blocks repeat casts until release.
// Ports   : clk, rst (async, active-high)
//           voter_id/voter_id_valid, voter_voted, candidate_btn, confirm_btn, cancel_btn (in)
//           ready, candidate_select, voter_select, vote_cast, candidate_number,
//           voter_number, err_valid, err_code, votes_total (out)
// Config  : VOTE_CONFIRM_EN - adds a CONFIRM step between the press and the cast.
module vote_session_controller
  import evm_pkg::*;
#(
  parameter int NUM_CANDIDATES = DEF_NUM_CANDIDATES,
  parameter int NUM_VOTERS     = DEF_NUM_VOTERS,
  parameter int ID_W           = DEF_ID_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int TOTAL_W        = DEF_TOTAL_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ID_W-1:0]           voter_id,
  input  logic                      voter_id_valid,
  input  logic [NUM_VOTERS-1:0]     voter_voted,
  input  logic [NUM_CANDIDATES-1:0] candidate_btn,
  input  logic                      confirm_btn,
  input  logic                      cancel_btn,
  output logic                      ready,
  output logic [NUM_CANDIDATES-1:0] candidate_select,
  output logic [NUM_VOTERS-1:0]     voter_select,
  output logic                      vote_cast,
  output logic [ID_W-1:0]           candidate_number,
  output logic [ID_W-1:0]           voter_number,
  output logic                      err_valid,
  output logic [1:0]                err_code,
  output logic [TOTAL_W-1:0]        votes_total
);

  session_state_t            state;
  logic [NUM_CANDIDATES-1:0] cand_latched;
  logic                      multi_seen;   // inside a multi-press episode already reported
  logic                      btn_multi;
  logic                      btn_single;
  logic [ID_W-1:0]           btn_idx;
  logic                      id_bad;
  logic                      id_voted;
  logic                      timer_load;
  logic                      timer_en;
  logic                      timer_expired;

`ifndef VOTE_CONFIRM_EN
  logic unused_confirm_inputs;
  assign unused_confirm_inputs = confirm_btn | cancel_btn;
`endif

  // More than one bit set iff clearing the lowest set bit leaves something.
  assign btn_multi  = |(candidate_btn & (candidate_btn - NUM_CANDIDATES'(1)));
  assign btn_single = (|candidate_btn) && !btn_multi;

  always_comb begin
    btn_idx = '0;
    for (int i = 0; i < NUM_CANDIDATES; i++) begin
      if (candidate_btn[i]) btn_idx = ID_W'(i);
    end
  end

  // Checks use the latched ID; the live bus is ignored once the session starts.
  assign id_bad   = 32'(voter_number) >= NUM_VOTERS;
  assign id_voted = |(voter_voted & (NUM_VOTERS'(1) << voter_number));

  assign ready = (state == S_IDLE);

`ifdef VOTE_CONFIRM_EN
  assign timer_load = (state == S_AUTH) || (state == S_CONFIRM && cancel_btn);
  assign timer_en   = (state == S_SELECT) || (state == S_CONFIRM);
`else
  assign timer_load = (state == S_AUTH);
  assign timer_en   = (state == S_SELECT);
`endif

  session_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load),
    .en     (timer_en),
    .expired(timer_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      cand_latched     <= '0;
      multi_seen       <= 1'b0;
      candidate_select <= '0;
      voter_select     <= '0;
      vote_cast        <= 1'b0;
      candidate_number <= '0;
      voter_number     <= '0;
      err_valid        <= 1'b0;
      err_code         <= 2'd0;
      votes_total      <= '0;
    end else begin
      vote_cast        <= 1'b0;
      err_valid        <= 1'b0;
      candidate_select <= '0;
      voter_select     <= '0;
      case (state)
        S_IDLE: begin
          if (voter_id_valid) begin
            voter_number <= voter_id;
            state        <= S_AUTH;
          end
        end
        S_AUTH: begin
          if (id_bad) begin
            err_valid <= 1'b1;
            err_code  <= ERR_BAD_ID;
            state     <= S_IDLE;
          end else if (id_voted) begin
            err_valid <= 1'b1;
            err_code  <= ERR_ALREADY_VOTED;
            state     <= S_IDLE;
          end else begin
            multi_seen <= 1'b0;
            state      <= S_SELECT;
          end
        end
        S_SELECT: begin
          // A valid press beats a timeout landing in the same cycle.
          if (btn_single) begin
            cand_latched     <= candidate_btn;
            candidate_number <= btn_idx;
            multi_seen       <= 1'b0;
`ifdef VOTE_CONFIRM_EN
            state            <= S_CONFIRM;
`else
            state            <= S_CAST;
`endif
          end else if (timer_expired) begin
            err_valid <= 1'b1;
            err_code  <= ERR_TIMEOUT;
            state     <= S_IDLE;
          end else if (btn_multi) begin
            if (!multi_seen) begin
              err_valid <= 1'b1;
              err_code  <= ERR_MULTI_PRESS;
            end
            multi_seen <= 1'b1;
          end else begin
            multi_seen <= 1'b0;
          end
        end
`ifdef VOTE_CONFIRM_EN
        S_CONFIRM: begin
          if (cancel_btn) begin
            multi_seen <= 1'b0;
            state      <= S_SELECT;
          end else if (confirm_btn) begin
            state <= S_CAST;
          end else if (timer_expired) begin
            err_valid <= 1'b1;
            err_code  <= ERR_TIMEOUT;
            state     <= S_IDLE;
          end
        end
`endif
        S_CAST: begin
          vote_cast        <= 1'b1;
          candidate_select <= cand_latched;
          voter_select     <= NUM_VOTERS'(1) << voter_number;
          if (votes_total != '1) votes_total <= votes_total + TOTAL_W'(1);
          state            <= S_LOCK;
        end
        S_LOCK: begin
          // Held buttons or a held ID must not start a second session.
          if (candidate_btn == '0 && !voter_id_valid) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vote_session_controller.sv
// tb/tb_vote_session_controller.sv - self-checking bench for vote_session_controller
module tb_vote_session_controller;

  localparam int NC  = 3;
  localparam int NV  = 4;
  localparam int IDW = 4;
  localparam int TO  = 8;
  localparam int TW  = 8;
  localparam int TOTAL_MAX = (1 << TW) - 1;

  logic           clk = 1'b0;
  logic           rst;
  logic [IDW-1:0] voter_id;
  logic           voter_id_valid;
  logic [NV-1:0]  voter_voted;
  logic [NC-1:0]  candidate_btn;
  logic           confirm_btn;
  logic           cancel_btn;
  logic           ready;
  logic [NC-1:0]  candidate_select;
  logic [NV-1:0]  voter_select;
  logic           vote_cast;
  logic [IDW-1:0] candidate_number;
  logic [IDW-1:0] voter_number;
  logic           err_valid;
  logic [1:0]     err_code;
  logic [TW-1:0]  votes_total;

  always #5 clk = ~clk;

  vote_session_controller #(
    .NUM_CANDIDATES(NC), .NUM_VOTERS(NV), .ID_W(IDW), .TIMEOUT_CYCLES(TO), .TOTAL_W(TW)
  ) dut (
    .clk(clk), .rst(rst), .voter_id(voter_id), .voter_id_valid(voter_id_valid),
    .voter_voted(voter_voted), .candidate_btn(candidate_btn), .confirm_btn(confirm_btn),
    .cancel_btn(cancel_btn), .ready(ready), .candidate_select(candidate_select),
    .voter_select(voter_select), .vote_cast(vote_cast), .candidate_number(candidate_number),
    .voter_number(voter_number), .err_valid(err_valid), .err_code(err_code),
    .votes_total(votes_total)
  );

  int checks = 0;
  int failures = 0;
  int n_cast, n_err, cyc, err_cyc, cast_cyc;
  int model_total = 0;
  logic [NC-1:0]  last_csel;
  logic [NV-1:0]  last_vsel;
  logic [IDW-1:0] last_cnum;
  logic [TW-1:0]  last_total;
  logic [1:0]     last_code;
  logic [NC-1:0]  sq[$];

`ifdef VOTE_CONFIRM_EN
  localparam int CONFIRM_LAT = 1;
`else
  localparam int CONFIRM_LAT = 0;
`endif

  task automatic clear_obs();
    n_cast = 0; n_err = 0; cyc = 0; err_cyc = -1; cast_cyc = -1;
  endtask

  // Advance one clock and record any strobes, sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk); #1;
    cyc++;
    if (vote_cast === 1'b1) begin
      n_cast++; cast_cyc = cyc;
      last_csel = candidate_select; last_vsel = voter_select;
      last_cnum = candidate_number; last_total = votes_total;
    end
    if (err_valid === 1'b1) begin
      n_err++; err_cyc = cyc; last_code = err_code;
    end
  endtask

  function automatic int model_inc(input int t);
    return (t < TOTAL_MAX) ? t + 1 : TOTAL_MAX;
  endfunction

  // Present an ID, then apply sq one entry per selection cycle; the session
  // is then given enough idle cycles to finish (cast, error or timeout).
  task automatic run_session(input int id, input logic [NV-1:0] voted);
    clear_obs();
    voter_voted = voted; voter_id = IDW'(id); voter_id_valid = 1'b1;
    step();
    voter_id_valid = 1'b0; voter_id = IDW'($urandom);
    step();
    for (int i = 0; i < sq.size(); i++) begin
      candidate_btn = sq[i];
      step();
`ifdef VOTE_CONFIRM_EN
      if ($countones(sq[i]) == 1) begin
        candidate_btn = '0; confirm_btn = 1'b1; step(); confirm_btn = 1'b0;
        break;
      end
`endif
    end
    candidate_btn = '0;
    while (cyc < TO + 8) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; voter_id = '0; voter_id_valid = 1'b0; voter_voted = '0;
    candidate_btn = '0; confirm_btn = 1'b0; cancel_btn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
    checks++; if (vote_cast !== 1'b0 || err_valid !== 1'b0) begin failures++; $display("FAIL reset_strobes got cast=%b err=%b exp=0", vote_cast, err_valid); end
    checks++; if (votes_total !== '0 || err_code !== 2'd0 || candidate_number !== '0 || voter_number !== '0) begin
      failures++; $display("FAIL reset_regs got total=%0d code=%0d cnum=%0d vnum=%0d exp=0", votes_total, err_code, candidate_number, voter_number); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic_cast();
    sq = {3'b010};
    run_session(2, 4'b0000);
    model_total = model_inc(model_total);
    checks++; if (n_cast !== 1) begin failures++; $display("FAIL basic_cast_count got=%0d exp=1", n_cast); end
    checks++; if (last_csel !== 3'b010 || last_vsel !== 4'b0100) begin failures++; $display("FAIL basic_selects got=%b/%b exp=010/0100", last_csel, last_vsel); end
    checks++; if (last_cnum !== 4'd1 || voter_number !== 4'd2) begin failures++; $display("FAIL basic_numbers got cnum=%0d vnum=%0d exp=1/2", last_cnum, voter_number); end
    checks++; if (last_total !== TW'(model_total)) begin failures++; $display("FAIL basic_total got=%0d exp=%0d", last_total, model_total); end
    checks++; if (cast_cyc !== 4 + CONFIRM_LAT) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", cast_cyc, 4 + CONFIRM_LAT); end
    checks++; if (n_err !== 0 || ready !== 1'b1) begin failures++; $display("FAIL basic_clean got err=%0d ready=%b exp=0/1", n_err, ready); end
  endtask

  task automatic test_bad_id();
    sq = {};
    run_session(5, 4'b0000);
    checks++; if (n_err !== 1 || last_code !== 2'd0 || err_cyc !== 2) begin
      failures++; $display("FAIL bad_id_err got n=%0d code=%0d cyc=%0d exp=1/0/2", n_err, last_code, err_cyc); end
    checks++; if (n_cast !== 0 || ready !== 1'b1) begin failures++; $display("FAIL bad_id_nocast got cast=%0d ready=%b exp=0/1", n_cast, ready); end
  endtask

  task automatic test_already_voted();
    sq = {3'b001};
    run_session(0, 4'b0001);
    checks++; if (n_err !== 1 || last_code !== 2'd1) begin failures++; $display("FAIL voted_err got n=%0d code=%0d exp=1/1", n_err, last_code); end
    checks++; if (n_cast !== 0) begin failures++; $display("FAIL voted_nocast got=%0d exp=0", n_cast); end
  endtask

  task automatic test_multi_press();
    sq = {3'b101, 3'b101, 3'b101, 3'b100};
    run_session(3, 4'b0000);
    model_total = model_inc(model_total);
    checks++; if (n_err !== 1 || last_code !== 2'd2 || err_cyc !== 3) begin
      failures++; $display("FAIL multi_err got n=%0d code=%0d cyc=%0d exp=1/2/3", n_err, last_code, err_cyc); end
    checks++; if (n_cast !== 1 || last_csel !== 3'b100 || last_cnum !== 4'd2) begin
      failures++; $display("FAIL multi_cast got n=%0d csel=%b cnum=%0d exp=1/100/2", n_cast, last_csel, last_cnum); end
  endtask

  task automatic test_timeout();
    sq = {};
    for (int i = 0; i < TO; i++) sq.push_back(3'b000);
    run_session(1, 4'b0000);
    checks++; if (n_err !== 1 || last_code !== 2'd3 || err_cyc !== TO + 2) begin
      failures++; $display("FAIL timeout_err got n=%0d code=%0d cyc=%0d exp=1/3/%0d", n_err, last_code, err_cyc, TO + 2); end
    checks++; if (n_cast !== 0 || ready !== 1'b1) begin failures++; $display("FAIL timeout_idle got cast=%0d ready=%b exp=0/1", n_cast, ready); end
  endtask

  task automatic test_lock_hold();
    clear_obs();
    voter_voted = '0; voter_id = 4'd1; voter_id_valid = 1'b1;
    step(); step();
    candidate_btn = 3'b100;
    step();
`ifdef VOTE_CONFIRM_EN
    confirm_btn = 1'b1; step(); confirm_btn = 1'b0;
`endif
    repeat (22) step();
    model_total = model_inc(model_total);
    checks++; if (n_cast !== 1 || ready !== 1'b0) begin failures++; $display("FAIL lock_held got cast=%0d ready=%b exp=1/0", n_cast, ready); end
    checks++; if (last_vsel !== 4'b0010 || last_total !== TW'(model_total)) begin
      failures++; $display("FAIL lock_cast got vsel=%b total=%0d exp=0010/%0d", last_vsel, last_total, model_total); end
    candidate_btn = '0;
    step(); step();
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL lock_id_held got ready=%b exp=0", ready); end
    voter_id_valid = 1'b0;
    step(); step();
    checks++; if (ready !== 1'b1 || n_cast !== 1) begin failures++; $display("FAIL lock_release got ready=%b cast=%0d exp=1/1", ready, n_cast); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int id, len, found;
      logic [NV-1:0] voted;
      logic [NC-1:0] v;
      logic [1:0] exp_errs[$];
      bit in_multi;
      id = $urandom_range(0, 7); voted = NV'($urandom); len = $urandom_range(1, TO);
      sq = {}; exp_errs = {}; found = -1; in_multi = 0;
      for (int i = 0; i < len; i++) begin
        int r;
        r = $urandom_range(0, 9);
        if (r < 5) v = '0;
        else if (r < 8) v = NC'(1) << $urandom_range(0, NC - 1);
        else v = (r == 8) ? 3'b011 : 3'b111;
        if (i == TO - 1 && $countones(v) > 1) v = '0;
        sq.push_back(v);
      end
      if (id >= NV) exp_errs.push_back(2'd0);
      else if (voted[id]) exp_errs.push_back(2'd1);
      else begin
        for (int i = 0; i < TO; i++) begin
          v = (i < len) ? sq[i] : '0;
          if ($countones(v) == 1) begin found = i; break; end
          if ($countones(v) > 1 && !in_multi) exp_errs.push_back(2'd2);
          in_multi = ($countones(v) > 1);
        end
        if (found < 0) exp_errs.push_back(2'd3);
      end
      if (found >= 0) while (sq.size() > found + 1) void'(sq.pop_back());
      run_session(id, voted);
      checks++; if (n_cast !== (found >= 0 ? 1 : 0)) begin failures++; $display("FAIL rnd%0d_cast got=%0d exp=%0d", n, n_cast, found >= 0); end
      checks++; if (n_err !== exp_errs.size()) begin failures++; $display("FAIL rnd%0d_errs got=%0d exp=%0d", n, n_err, exp_errs.size()); end
      if (exp_errs.size() > 0) begin
        checks++; if (last_code !== exp_errs[exp_errs.size() - 1]) begin
          failures++; $display("FAIL rnd%0d_code got=%0d exp=%0d", n, last_code, exp_errs[exp_errs.size() - 1]); end
      end
      if (found >= 0 && n_cast == 1) begin
        model_total = model_inc(model_total);
        checks++; if (last_csel !== sq[found] || last_vsel !== NV'(1) << id || 32'(last_cnum) != $clog2(32'(sq[found])) || last_total !== TW'(model_total)) begin
          failures++; $display("FAIL rnd%0d_data got csel=%b vsel=%b cnum=%0d total=%0d exp=%b id=%0d total=%0d", n, last_csel, last_vsel, last_cnum, last_total, sq[found], id, model_total); end
      end
      checks++; if (ready !== 1'b1) begin failures++; $display("FAIL rnd%0d_ready got=%b exp=1", n, ready); end
    end
  endtask

  task automatic test_reset_mid_session();
    clear_obs();
    voter_voted = '0; voter_id = 4'd0; voter_id_valid = 1'b1;
    step();
    voter_id_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    #1;
    checks++; if (ready !== 1'b1 || vote_cast !== 1'b0 || err_valid !== 1'b0) begin
      failures++; $display("FAIL rstmid_async got ready=%b cast=%b err=%b exp=1/0/0", ready, vote_cast, err_valid); end
    checks++; if (votes_total !== '0 || err_code !== 2'd0 || candidate_select !== '0 || voter_select !== '0) begin
      failures++; $display("FAIL rstmid_regs got total=%0d code=%0d csel=%b vsel=%b exp=0", votes_total, err_code, candidate_select, voter_select); end
    candidate_btn = 3'b001;
    step(); step();
    rst = 1'b0; candidate_btn = '0;
    repeat (4) step();
    model_total = 0;
    checks++; if (n_cast !== 0 || n_err !== 0 || ready !== 1'b1 || votes_total !== '0) begin
      failures++; $display("FAIL rstmid_after got cast=%0d err=%0d ready=%b total=%0d exp=0/0/1/0", n_cast, n_err, ready, votes_total); end
  endtask

  task automatic test_saturation();
    for (int n = 0; n < TOTAL_MAX + 3; n++) begin
      sq = {NC'(1) << $urandom_range(0, NC - 1)};
      run_session(n % NV, 4'b0000);
      model_total = model_inc(model_total);
      checks++; if (n_cast !== 1 || last_total !== TW'(model_total)) begin
        failures++; $display("FAIL sat%0d got cast=%0d total=%0d exp=1/%0d", n, n_cast, last_total, model_total); end
    end
    checks++; if (votes_total !== TW'(TOTAL_MAX)) begin failures++; $display("FAIL sat_final got=%0d exp=%0d", votes_total, TOTAL_MAX); end
  endtask

`ifdef VOTE_CONFIRM_EN
  task automatic test_confirm();
    clear_obs();
    voter_voted = '0; voter_id = 4'd3; voter_id_valid = 1'b1;
    step();
    voter_id_valid = 1'b0;
    step();
    candidate_btn = 3'b010; step(); candidate_btn = '0;
    cancel_btn = 1'b1; step(); cancel_btn = 1'b0;
    step(); step();
    checks++; if (n_cast !== 0) begin failures++; $display("FAIL confirm_cancel got=%0d exp=0", n_cast); end
    candidate_btn = 3'b001; step(); candidate_btn = '0;
    confirm_btn = 1'b1; cancel_btn = 1'b1; step(); cancel_btn = 1'b0;
    step(); step();
    checks++; if (n_cast !== 0) begin failures++; $display("FAIL confirm_cancel_wins got=%0d exp=0", n_cast); end
    candidate_btn = 3'b100; confirm_btn = 1'b0; step(); candidate_btn = '0;
    confirm_btn = 1'b1; step(); confirm_btn = 1'b0;
    repeat (4) step();
    model_total = model_inc(model_total);
    checks++; if (n_cast !== 1 || last_csel !== 3'b100 || last_vsel !== 4'b1000 || last_total !== TW'(model_total)) begin
      failures++; $display("FAIL confirm_cast got n=%0d csel=%b vsel=%b total=%0d exp=1/100/1000/%0d", n_cast, last_csel, last_vsel, last_total, model_total); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_cast();
    test_bad_id();
    test_already_voted();
    test_multi_press();
    test_timeout();
    test_lock_hold();
    test_random();
    test_reset_mid_session();
    test_saturation();
`ifdef VOTE_CONFIRM_EN
    test_confirm();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
